// File: rtl/vga_timing_pkg.sv
// Timing constants and helpers shared by the VGA timing generator.
// Defaults describe 640x480@60 (800 x 525 totals).
// Combinational helpers only; no state.
package vga_timing_pkg;

    localparam int unsigned CW_D       = 10;

    localparam int unsigned H_ACTIVE_D = 640;
    localparam int unsigned H_FP_D     = 16;
    localparam int unsigned H_SYNC_D   = 96;
    localparam int unsigned H_BP_D     = 48;

    localparam int unsigned V_ACTIVE_D = 480;
    localparam int unsigned V_FP_D     = 10;
    localparam int unsigned V_SYNC_D   = 2;
    localparam int unsigned V_BP_D     = 33;

    localparam int unsigned H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int unsigned V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

    // First count inside the sync window: right after the front porch.
    function automatic int unsigned sync_start(input int unsigned active,
                                               input int unsigned fp);
        return active + fp;
    endfunction

    // Last count inside the sync window (inclusive).
    function automatic int unsigned sync_end(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned width);
        return active + fp + width - 1;
    endfunction

    localparam int unsigned H_SYNC_START_D = sync_start(H_ACTIVE_D, H_FP_D);
    localparam int unsigned H_SYNC_END_D   = sync_end(H_ACTIVE_D, H_FP_D, H_SYNC_D);
    localparam int unsigned V_SYNC_START_D = sync_start(V_ACTIVE_D, V_FP_D);
    localparam int unsigned V_SYNC_END_D   = sync_end(V_ACTIVE_D, V_FP_D, V_SYNC_D);

endpackage

// File: rtl/vga_timing_gen_rise_strobe.sv
// Rising-edge detector for a slow toggle sampled as data in the clk domain.
// Strobe is combinational, high in the clk where the new high level is first seen.
// No backpressure; falling edges produce nothing.
module rise_strobe (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stb
);

    logic din_q;

    // Previous-cycle sample of the input level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign stb = din & ~din_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel strobe drives h/v counters, registered sync/video/coords.
// Outputs lag counter changes by 1 clk; frame_start lines up with outputs showing (0,0).
// No backpressure; counters free-run on every pixel strobe.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_D,
    parameter int unsigned H_FP     = H_FP_D,
    parameter int unsigned H_SYNC   = H_SYNC_D,
    parameter int unsigned H_BP     = H_BP_D,
    parameter int unsigned V_ACTIVE = V_ACTIVE_D,
    parameter int unsigned V_FP     = V_FP_D,
    parameter int unsigned V_SYNC   = V_SYNC_D,
    parameter int unsigned V_BP     = V_BP_D,
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned CW       = CW_D
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_clk_in,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          frame_start
);

    localparam logic [CW-1:0] H_LAST   = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(sync_start(H_ACTIVE, H_FP));
    localparam logic [CW-1:0] HS_END   = CW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [CW-1:0] VS_START = CW'(sync_start(V_ACTIVE, V_FP));
    localparam logic [CW-1:0] VS_END   = CW'(sync_end(V_ACTIVE, V_FP, V_SYNC));
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic          pix_stb;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          wrap_q;
    logic          h_in_sync;
    logic          v_in_sync;

    rise_strobe u_rise (
        .clk (clk),
        .rst (rst),
        .din (pix_clk_in),
        .stb (pix_stb)
    );

    assign h_in_sync = (hcnt >= HS_START) && (hcnt <= HS_END);
    assign v_in_sync = (vcnt >= VS_START) && (vcnt <= VS_END);

    // Raster counters; vcnt steps only when hcnt wraps. wrap_q marks the
    // counters having just returned to (0,0) from the last pixel of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt   <= '0;
            vcnt   <= '0;
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= pix_stb && (hcnt == H_LAST) && (vcnt == V_LAST);
            if (pix_stb) begin
                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    if (vcnt == V_LAST) begin
                        vcnt <= '0;
                    end else begin
                        vcnt <= vcnt + ONE;
                    end
                end else begin
                    hcnt <= hcnt + ONE;
                end
            end
        end
    end

    // Registered decode of the counters, refreshed every clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            video_on    <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            x           <= hcnt;
            y           <= vcnt;
            video_on    <= (hcnt < H_VIS) && (vcnt < V_VIS);
            hsync       <= h_in_sync ? SYNC_POL : ~SYNC_POL;
            vsync       <= v_in_sync ? SYNC_POL : ~SYNC_POL;
            frame_start <= wrap_q;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance (active-low sync) and a tiny
// raster instance with active-high sync used to cover whole frames quickly.
// All expected values are hand-derived constants or simple window models.
module tb_vga_timing_gen;

    logic       clk;
    logic       rst_a, rst_b;
    logic       pix_a, pix_b;
    logic       hs_a, vs_a, vo_a, fs_a;
    logic       hs_b, vs_b, vo_b, fs_b;
    logic [9:0] x_a, y_a, x_b, y_b;

    int checks = 0;
    int errors = 0;
    int ph     = 0;

    vga_timing_gen u_dut (
        .clk         (clk),
        .rst         (rst_a),
        .pix_clk_in  (pix_a),
        .hsync       (hs_a),
        .vsync       (vs_a),
        .video_on    (vo_a),
        .x           (x_a),
        .y           (y_a),
        .frame_start (fs_a)
    );

    // 15 x 10 raster: hsync window 10..12, vsync window 7..8, active 8 x 6.
    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
        .SYNC_POL (1'b1), .CW (10)
    ) u_small (
        .clk         (clk),
        .rst         (rst_b),
        .pix_clk_in  (pix_b),
        .hsync       (hs_b),
        .vsync       (vs_b),
        .video_on    (vo_b),
        .x           (x_b),
        .y           (y_b),
        .frame_start (fs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Divider model: pix_a toggles every 2 clk (rising edge every 4 clk).
    task automatic tick_a();
        tick();
        ph++;
        if (ph == 2) begin
            ph    = 0;
            pix_a = ~pix_a;
        end
    endtask

    task automatic tick_b();
        tick();
        pix_b = ~pix_b;
    endtask

    initial begin
        int  hs_lo, first_lo, last_lo, vo639, vo640, prev_x, x0, fs_seen;
        int  nfs, first_t, second_t, hs_hi, vs_hi, hs_bad, vo_bad;
        bit  wrapped, reached;

        rst_a = 1'b1; rst_b = 1'b1; pix_a = 1'b0; pix_b = 1'b0;
        repeat (3) tick();
        chk("rst_x", x_a, 0);
        chk("rst_y", y_a, 0);
        chk("rst_video_on", vo_a, 0);
        chk("rst_hsync", hs_a, 1);
        chk("rst_vsync", vs_a, 1);
        chk("rst_frame_start", fs_a, 0);
        chk("rst_hsync_pos", hs_b, 0);
        chk("rst_vsync_pos", vs_b, 0);

        // Release and watch the first counted edges.
        rst_a = 1'b0; ph = 0;
        tick_a();
        chk("first_video_on", vo_a, 1);
        chk("first_x", x_a, 0);
        tick_a(); tick_a();
        chk("x_before_lag", x_a, 0);
        tick_a();
        chk("x_after_first_stb", x_a, 1);
        repeat (4) tick_a();
        chk("x_after_second_stb", x_a, 2);

        // One full line: hsync window and line wrap.
        hs_lo = 0; first_lo = -1; last_lo = -1; vo639 = -1; vo640 = -1;
        wrapped = 1'b0; prev_x = x_a;
        for (int i = 0; i < 4000 && !wrapped; i++) begin
            tick_a();
            if (hs_a == 1'b0) begin
                hs_lo++;
                if (first_lo < 0) first_lo = x_a;
                last_lo = x_a;
            end
            if (x_a == 639) vo639 = vo_a;
            if (x_a == 640) vo640 = vo_a;
            if (prev_x == 799 && x_a == 0) begin
                wrapped = 1'b1;
                chk("wrap_y", y_a, 1);
            end
            prev_x = x_a;
        end
        chk("line_wrapped", wrapped, 1);
        chk("hsync_low_clks", hs_lo, 384);
        chk("hsync_first_x", first_lo, 656);
        chk("hsync_last_x", last_lo, 751);
        chk("video_on_x639", vo639, 1);
        chk("video_on_x640", vo640, 0);
        chk("vsync_line1", vs_a, 1);

        // Stuck input: one strobe total across a long high then a long low.
        pix_a = 1'b0;
        repeat (3) tick();
        x0 = x_a;
        pix_a = 1'b1;
        repeat (100) tick();
        chk("hold_high_x", x_a, x0 + 1);
        pix_a = 1'b0;
        repeat (100) tick();
        chk("hold_low_x", x_a, x0 + 1);

        // Run to x=300 and reset mid-line.
        ph = 0; reached = 1'b0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            tick_a();
            if (x_a == 300) reached = 1'b1;
        end
        chk("reached_x300", reached, 1);
        chk("pre_rst_y", y_a, 1);
        #2 rst_a = 1'b1;
        #1;
        chk("async_rst_x", x_a, 0);
        chk("async_rst_y", y_a, 0);
        chk("async_rst_video_on", vo_a, 0);
        chk("async_rst_hsync", hs_a, 1);
        chk("async_rst_vsync", vs_a, 1);
        chk("async_rst_frame_start", fs_a, 0);
        tick(); tick();
        rst_a = 1'b0; pix_a = 1'b0; ph = 0; fs_seen = 0;
        for (int i = 0; i < 400; i++) begin
            tick_a();
            fs_seen += int'(fs_a);
            if (i == 0) begin
                chk("restart_x", x_a, 0);
                chk("restart_y", y_a, 0);
                chk("restart_video_on", vo_a, 1);
            end
        end
        chk("no_frame_start_after_rst", fs_seen, 0);
        chk("restart_x_after_400", x_a, 100);

        // Small raster, SYNC_POL=1, strobe every 2 clk: frame = 300 clk.
        tick();
        rst_b = 1'b0; pix_b = 1'b0;
        nfs = 0; first_t = -1; second_t = -1;
        hs_hi = 0; vs_hi = 0; hs_bad = 0; vo_bad = 0;
        for (int t = 1; t <= 700; t++) begin
            tick_b();
            if (fs_b) begin
                nfs++;
                if (nfs == 1) first_t = t;
                if (nfs == 2) second_t = t;
                chk("frame_start_x", x_b, 0);
                chk("frame_start_y", y_b, 0);
            end
            if (nfs == 1) begin
                hs_hi += int'(hs_b);
                vs_hi += int'(vs_b);
            end
            if (hs_b != ((x_b >= 10 && x_b <= 12) ? 1'b1 : 1'b0)) hs_bad++;
            if (vo_b != ((x_b < 8 && y_b < 6) ? 1'b1 : 1'b0)) vo_bad++;
        end
        chk("frame_start_count", nfs, 2);
        chk("frame_start_first_t", first_t, 301);
        chk("frame_period", second_t - first_t, 300);
        chk("hsync_high_clks", hs_hi, 60);
        chk("vsync_high_clks", vs_hi, 60);
        chk("hsync_window_bad", hs_bad, 0);
        chk("video_on_bad", vo_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
